// File: rtl/out_slice_merge_buf.sv
// out_slice_merge_buf: per-channel slice output FIFOs merged back into raster picture lines.
// Channel c's line k is emitted after channel c-1's line k; channel-0 SOF restarts the merge.
module out_slice_merge_buf #(
    parameter int NUM_CH          = 4,
    parameter int NUMBER_OF_LINES = 1280,
    parameter int DATA_WIDTH      = 168,
    parameter int MAX_SLICE_WIDTH = 2560,
    parameter int PIX_PER_WORD    = 4,
    parameter int ID              = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [$clog2(MAX_SLICE_WIDTH)-1:0] slice_width,
    input  logic [$clog2(NUM_CH+1)-1:0]        num_slices,
    input  logic [$clog2(NUMBER_OF_LINES):0]   almost_full_thres,
    input  logic [$clog2(NUMBER_OF_LINES):0]   almost_empty_thres,
    input  logic [NUM_CH*DATA_WIDTH-1:0]       in_data,
    input  logic [NUM_CH-1:0]                  in_valid,
    input  logic [NUM_CH-1:0]                  in_sof,
    output logic [NUM_CH-1:0]                  fifo_almost_full,
    output logic [NUM_CH-1:0]                  fifo_almost_empty,
    output logic [NUM_CH-1:0]                  overflow,
    input  logic                               out_ready,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic                               out_valid,
    output logic                               out_sof,
    output logic                               out_eol,
    output logic [$clog2(NUM_CH)-1:0]          out_ch
);
    localparam int SW  = $clog2(MAX_SLICE_WIDTH);
    localparam int NSW = $clog2(NUM_CH+1);
    localparam int AW  = $clog2(NUMBER_OF_LINES);
    localparam int TW  = AW + 1;
    localparam int CHW = $clog2(NUM_CH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state, state_nxt;
    logic [SW-1:0]         fs_raw;
    logic [TW-1:0]         fifo_size;
    logic [AW-1:0]         ptr_last;
    logic [SW:0]           wpl;
    logic [AW-1:0]         wptr [NUM_CH];
    logic [AW-1:0]         rptr [NUM_CH];
    logic [TW-1:0]         count [NUM_CH];
    logic [DATA_WIDTH-1:0] rd_q [NUM_CH];
    logic [NUM_CH-1:0]     wr_sof, wr_en, wr_drop, has_room, rd_en;
    logic [TW-1:0]         cur_cnt;
    logic                  sof0, rd_fire, last_word, last_ch;
    logic [CHW-1:0]        cur_ch, cur_ch_nxt, out_ch_nxt;
    logic [SW:0]           word_cnt, word_cnt_nxt;
    logic                  first, first_nxt;
    logic                  out_valid_nxt, out_sof_nxt, out_eol_nxt;

    // Depth tracks half the slice width with a 128-word floor, capped by the physical memory.
    assign fs_raw    = (slice_width < SW'(256)) ? SW'(128) : (slice_width >> 1);
    assign fifo_size = ({1'b0, fs_raw} > (SW+1)'(NUMBER_OF_LINES)) ? TW'(NUMBER_OF_LINES) : TW'(fs_raw);
    assign ptr_last  = AW'(fifo_size - TW'(1));
    assign wpl       = ({1'b0, slice_width} + (SW+1)'(PIX_PER_WORD - 1)) / (SW+1)'(PIX_PER_WORD);

    assign wr_sof  = in_valid & in_sof;
    assign wr_en   = in_valid & ~in_sof & has_room;
    assign wr_drop = in_valid & ~in_sof & ~has_room;

    assign sof0      = wr_sof[0];
    assign cur_cnt   = count[cur_ch];
    assign last_word = word_cnt == wpl - (SW+1)'(1);
    assign last_ch   = NSW'(cur_ch) == num_slices - NSW'(1);
    // A flush on the channel being merged wins over its read.
    assign rd_fire   = state == RUN && !sof0 && !wr_sof[cur_ch] && cur_cnt != '0 && (!out_valid || out_ready);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            has_room[i] = count[i] < fifo_size;
            rd_en[i]    = rd_fire && cur_ch == CHW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wptr[i]              <= '0;
                rptr[i]              <= '0;
                count[i]             <= '0;
                overflow[i]          <= 1'b0;
                fifo_almost_full[i]  <= 1'b0;
                fifo_almost_empty[i] <= 1'b1;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_sof[i]) begin
                    wptr[i]     <= AW'(1);
                    rptr[i]     <= '0;
                    count[i]    <= TW'(1);
                    overflow[i] <= 1'b0;
                end else begin
                    if (wr_en[i])
                        wptr[i] <= (wptr[i] >= ptr_last) ? '0 : wptr[i] + AW'(1);
                    if (rd_en[i])
                        rptr[i] <= (rptr[i] >= ptr_last) ? '0 : rptr[i] + AW'(1);
                    count[i] <= count[i] + TW'(wr_en[i]) - TW'(rd_en[i]);
                    if (wr_drop[i])
                        overflow[i] <= 1'b1;
                end
                fifo_almost_full[i]  <= count[i] > almost_full_thres;
                fifo_almost_empty[i] <= count[i] < almost_empty_thres;
            end
        end
    end

    // Read address never collides with a live write: reads need count>0, writes need room.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_WIDTH-1:0] mem [NUMBER_OF_LINES];
        always_ff @(posedge clk) begin
            if (wr_sof[c] || wr_en[c])
                mem[wr_sof[c] ? '0 : wptr[c]] <= in_data[c*DATA_WIDTH +: DATA_WIDTH];
            if (rd_en[c])
                rd_q[c] <= mem[rptr[c]];
        end
    end

    assign out_data = rd_q[out_ch];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_ch    <= '0;
            word_cnt  <= '0;
            first     <= 1'b0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_ch    <= '0;
        end else begin
            state     <= state_nxt;
            cur_ch    <= cur_ch_nxt;
            word_cnt  <= word_cnt_nxt;
            first     <= first_nxt;
            out_valid <= out_valid_nxt;
            out_sof   <= out_sof_nxt;
            out_eol   <= out_eol_nxt;
            out_ch    <= out_ch_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cur_ch_nxt    = cur_ch;
        word_cnt_nxt  = word_cnt;
        first_nxt     = first;
        out_valid_nxt = out_valid;
        out_sof_nxt   = out_sof;
        out_eol_nxt   = out_eol;
        out_ch_nxt    = out_ch;
        if (sof0) begin
            state_nxt     = RUN;
            cur_ch_nxt    = '0;
            word_cnt_nxt  = '0;
            first_nxt     = 1'b1;
            out_valid_nxt = 1'b0;
            out_sof_nxt   = 1'b0;
            out_eol_nxt   = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid_nxt = 1'b0;
                out_sof_nxt   = 1'b0;
                out_eol_nxt   = 1'b0;
            end
            if (rd_fire) begin
                out_valid_nxt = 1'b1;
                out_sof_nxt   = first;
                out_eol_nxt   = last_word && last_ch;
                out_ch_nxt    = cur_ch;
                first_nxt     = 1'b0;
                word_cnt_nxt  = last_word ? '0 : word_cnt + (SW+1)'(1);
                cur_ch_nxt    = !last_word ? cur_ch : last_ch ? '0 : cur_ch + CHW'(1);
            end
        end
    end

    // The channel being merged can never hold more words than the configured depth.
    assert property (@(posedge clk) disable iff (!rst_n) cur_cnt <= fifo_size)
        else $error("out_slice_merge_buf[%0d]: channel %0d fullness exceeds depth", ID, cur_ch);

endmodule
